// File: rtl/control_fsm.sv
// Multicycle control FSM for Instruction_FD: FETCH/DECODE/EXEC/MEM/WB(/HALT), registered Moore strobes.
// Optional CONTROL_FSM_ILLEGAL_TRAP_EN: illegal opcodes trap to HALT instead of retiring as a NOP.
module control_fsm #(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        WE_mem,
    output logic        WE_reg,
    output logic [1:0]  OP_MEM_I,
    output logic        ADD_SUB,
    output logic        PC_load,
    output logic [2:0]  select_flags,
    output logic        illegal,
    output logic [2:0]  state_dbg
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [3:0] WAIT_LAST = FETCH_WAIT[3:0];

    logic [2:0]  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    // Only the decode-relevant fields of the instruction are kept: {funct7[5], funct3, opcode}.
    logic [10:0] ir_q, ir_d;
    logic        we_mem_q, we_mem_d, we_reg_q, we_reg_d;
    logic [1:0]  op_mem_q, op_mem_d;
    logic        add_sub_q, add_sub_d, pc_load_q, pc_load_d;
    logic [2:0]  sel_q, sel_d;
    logic        illegal_q, illegal_d;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7b5, fetch_last, in_ex;
    logic       is_r, is_addi, is_ld, is_sd, is_br, is_ill;

    assign opc        = ir_q[6:0];
    assign f3         = ir_q[9:7];
    assign f7b5       = ir_q[10];
    assign fetch_last = (state_q == S_FETCH) && (wait_q == WAIT_LAST);

    assign is_r    = (opc == 7'b0110011) && (f3 == 3'b000);
    assign is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
    assign is_ld   = (opc == 7'b0000011) && (f3 == 3'b011);
    assign is_sd   = (opc == 7'b0100011) && (f3 == 3'b011);
    assign is_br   = (opc == 7'b1100011) &&
                     ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101));
    assign is_ill  = !(is_r || is_addi || is_ld || is_sd || is_br);

    assign wait_d = (state_q == S_FETCH && !fetch_last) ? wait_q + 4'd1 : 4'd0;
    assign ir_d   = fetch_last ? {instr[30], instr[14:12], instr[6:0]} : ir_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (fetch_last) state_d = S_DECODE;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
            S_DECODE: state_d = is_ill ? S_HALT : S_EXEC;
`else
            S_DECODE: state_d = S_EXEC;
`endif
            S_EXEC: begin
                if (is_ld || is_sd)        state_d = S_MEM;
                else if (is_r || is_addi)  state_d = S_WB;
                else                       state_d = S_FETCH;
            end
            S_MEM:    state_d = is_ld ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Strobes are a Moore function of the state being entered, so they line up with state_dbg.
    always_comb begin
        in_ex     = (state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB);
        op_mem_d  = 2'd0;
        if (in_ex && is_addi)               op_mem_d = 2'd2;
        else if (in_ex && (is_ld || is_sd)) op_mem_d = 2'd1;
        add_sub_d = in_ex && ((is_r && f7b5) || is_br);
        we_mem_d  = (state_d == S_MEM) && is_sd;
        we_reg_d  = (state_d == S_WB);
        pc_load_d = ((state_d == S_EXEC) && (is_br || is_ill)) || we_mem_d || we_reg_d;
        sel_d     = 3'd0;
        if (state_d == S_EXEC && is_br) begin
            case (f3)
                3'b000:  sel_d = 3'd1;
                3'b001:  sel_d = 3'd2;
                3'b100:  sel_d = 3'd3;
                3'b101:  sel_d = 3'd4;
                default: sel_d = 3'd0;
            endcase
        end
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        illegal_d = (state_d == S_HALT);
`else
        illegal_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= 4'd0;
            ir_q      <= 11'd0;
            we_mem_q  <= 1'b0;
            we_reg_q  <= 1'b0;
            op_mem_q  <= 2'd0;
            add_sub_q <= 1'b0;
            pc_load_q <= 1'b0;
            sel_q     <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            ir_q      <= ir_d;
            we_mem_q  <= we_mem_d;
            we_reg_q  <= we_reg_d;
            op_mem_q  <= op_mem_d;
            add_sub_q <= add_sub_d;
            pc_load_q <= pc_load_d;
            sel_q     <= sel_d;
            illegal_q <= illegal_d;
        end
    end

    assign WE_mem       = we_mem_q;
    assign WE_reg       = we_reg_q;
    assign OP_MEM_I     = op_mem_q;
    assign ADD_SUB      = add_sub_q;
    assign PC_load      = pc_load_q;
    assign select_flags = sel_q;
    assign illegal      = illegal_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-cycle expected outputs are queued with each instruction and popped per edge.
module tb_control_fsm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst_w;
    logic [31:0] instr0, instr_w;
    logic        wm0, wr0, as0, pcl0, ill0, wm_w, wr_w, as_w, pcl_w, ill_w;
    logic [1:0]  op0, op_w;
    logic [2:0]  sel0, st0, sel_w, st_w;

    control_fsm #(.FETCH_WAIT(0)) dut (
        .clk(clk), .reset(rst0), .instr(instr0),
        .WE_mem(wm0), .WE_reg(wr0), .OP_MEM_I(op0), .ADD_SUB(as0),
        .PC_load(pcl0), .select_flags(sel0), .illegal(ill0), .state_dbg(st0)
    );

    control_fsm #(.FETCH_WAIT(2)) dut_w (
        .clk(clk), .reset(rst_w), .instr(instr_w),
        .WE_mem(wm_w), .WE_reg(wr_w), .OP_MEM_I(op_w), .ADD_SUB(as_w),
        .PC_load(pcl_w), .select_flags(sel_w), .illegal(ill_w), .state_dbg(st_w)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       wm;
        logic       wr;
        logic [1:0] op;
        logic       as;
        logic       pcl;
        logic [2:0] sel;
        logic       ill;
    } vec_t;

    localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

    vec_t  exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    use_w = 1'b0;
    string lbl = "";

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] st, input logic wm, input logic wr,
                                input logic [1:0] op, input logic as, input logic pcl,
                                input logic [2:0] sel, input logic ill);
        vec_t v;
        v.st = st; v.wm = wm; v.wr = wr; v.op = op; v.as = as; v.pcl = pcl; v.sel = sel; v.ill = ill;
        return v;
    endfunction

    function automatic vec_t obs();
        if (use_w) return mk(st_w, wm_w, wr_w, op_w, as_w, pcl_w, sel_w, ill_w);
        return mk(st0, wm0, wr0, op0, as0, pcl0, sel0, ill0);
    endfunction

    // Expected per-edge outputs of one instruction, from the architectural encoding of the opcode.
    function automatic void push_seq(input logic [31:0] ins, input int fw);
        logic [6:0] opc;
        logic [2:0] f3, sel;
        logic [1:0] op;
        logic       as, r, ai, ld, sd, br, ill;
        opc = ins[6:0];
        f3  = ins[14:12];
        r   = (opc == 7'h33) && (f3 == 3'd0);
        ai  = (opc == 7'h13) && (f3 == 3'd0);
        ld  = (opc == 7'h03) && (f3 == 3'd3);
        sd  = (opc == 7'h23) && (f3 == 3'd3);
        br  = (opc == 7'h63) && (f3 inside {3'd0, 3'd1, 3'd4, 3'd5});
        ill = !(r || ai || ld || sd || br);
        op  = ai ? 2'd2 : ((ld || sd) ? 2'd1 : 2'd0);
        as  = br || (r && ins[30]);
        sel = !br ? 3'd0 : (f3 == 3'd0) ? 3'd1 : (f3 == 3'd1) ? 3'd2 : (f3 == 3'd4) ? 3'd3 : 3'd4;
        for (int i = 0; i < fw; i++) exp_q.push_back(mk(3'd0, 0, 0, 2'd0, 0, 0, 3'd0, 0));
        exp_q.push_back(mk(3'd1, 0, 0, 2'd0, 0, 0, 3'd0, 0));
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        if (ill) begin
            exp_q.push_back(mk(3'd5, 0, 0, 2'd0, 0, 0, 3'd0, 1));
            return;
        end
`endif
        exp_q.push_back(mk(3'd2, 0, 0, op, as, br || ill, sel, 0));
        if (ld || sd) exp_q.push_back(mk(3'd3, sd, 0, op, as, sd, 3'd0, 0));
        if (r || ai || ld) exp_q.push_back(mk(3'd4, 0, 1, op, as, 1, 3'd0, 0));
        exp_q.push_back(mk(3'd0, 0, 0, 2'd0, 0, 0, 3'd0, 0));
    endfunction

    task automatic step();
        vec_t e, o;
        @(posedge clk);
        #1;
        o = obs();
        if (exp_q.size() == 0) begin
            check({lbl, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({lbl, ".state"},   32'(o.st),  32'(e.st));
            check({lbl, ".WE_mem"},  32'(o.wm),  32'(e.wm));
            check({lbl, ".WE_reg"},  32'(o.wr),  32'(e.wr));
            check({lbl, ".OP_MEM"},  32'(o.op),  32'(e.op));
            check({lbl, ".ADD_SUB"}, 32'(o.as),  32'(e.as));
            check({lbl, ".PC_load"}, 32'(o.pcl), 32'(e.pcl));
            check({lbl, ".sel"},     32'(o.sel), 32'(e.sel));
            check({lbl, ".illegal"}, 32'(o.ill), 32'(e.ill));
        end
    endtask

    // The real word is presented only on the last FETCH edge; junk everywhere else must be ignored.
    task automatic drive_seq(input logic [31:0] ins, input int fw, input string name);
        lbl = name;
        push_seq(ins, fw);
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (use_w) instr_w = (k == fw) ? ins : JUNK;
            else       instr0  = (k == fw) ? ins : JUNK;
            step();
        end
    endtask

    task automatic reset_step(input string name);
        lbl = name;
        exp_q.push_back(mk(3'd0, 0, 0, 2'd0, 0, 0, 3'd0, 0));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst0 = 1'b1; rst_w = 1'b1;
        instr0 = 32'h0010_3083; instr_w = JUNK;
        repeat (3) reset_step("reset");
        use_w = 1'b1;
        reset_step("reset_w");
        use_w = 1'b0;
        rst0 = 1'b0;

        drive_seq(32'h0010_3083, 0, "ld");
        drive_seq(32'h0020_81B3, 0, "add");
        drive_seq(32'h4011_8233, 0, "sub");
        drive_seq(32'h0030_31A3, 0, "sd");
        drive_seq(32'h0020_8463, 0, "beq");
        drive_seq(32'h0020_9463, 0, "bne");
        drive_seq(32'h0020_C463, 0, "blt");
        drive_seq(32'h0020_D463, 0, "bge");
        drive_seq(32'h00A2_0493, 0, "addi");
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        drive_seq(32'hFFFF_FFFF, 0, "trap");
        repeat (3) begin
            exp_q.push_back(mk(3'd5, 0, 0, 2'd0, 0, 0, 3'd0, 1));
            step();
        end
        rst0 = 1'b1;
        reset_step("trap_reset");
        rst0 = 1'b0;
        drive_seq(32'h0020_81B3, 0, "after_trap");
`else
        drive_seq(32'hFFFF_FFFF, 0, "nop_ill");
        drive_seq(32'h0020_A463, 0, "nop_br010");
`endif

        // Reset arriving on the MEM edge of a store must swallow WE_mem and PC_load.
        lbl = "sd_abort";
        instr0 = 32'h0030_31A3;
        exp_q.push_back(mk(3'd1, 0, 0, 2'd0, 0, 0, 3'd0, 0));
        step();
        instr0 = JUNK;
        exp_q.push_back(mk(3'd2, 0, 0, 2'd1, 0, 0, 3'd0, 0));
        step();
        rst0 = 1'b1;
        reset_step("sd_abort_rst");
        reset_step("sd_abort_rst");
        rst0 = 1'b0;
        drive_seq(32'h0010_3083, 0, "ld_after_abort");

        use_w = 1'b1;
        rst_w = 1'b0;
        drive_seq(32'h00A2_0493, 2, "addi_w");
        drive_seq(32'h0030_31A3, 2, "sd_w");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control unit for the processor datapath `Instruction_FD`. It samples the instruction word and sequences each instruction through fetch, decode, execute, memory and write-back states. It produces, cycle by cycle, the datapath strobes `WE_mem`, `WE_reg`, `OP_MEM_I`, `ADD_SUB`, `PC_load` and `select_flags`. It replaces the hand-driven control stimulus at the datapath's control inputs.

## Interface
- `FETCH_WAIT`, default 0: extra wait cycles spent in FETCH before the instruction is latched (range 0..15), for slow instruction memory.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instr` in 32: instruction word from instruction memory at the current PC.
- `WE_mem` out 1: data-memory write enable.
- `WE_reg` out 1: register-bank write enable.
- `OP_MEM_I` out 2: ALU B/address source select.
  - 0 = register rs2.
  - 1 = load/store offset.
  - 2 = I-type immediate.
- `ADD_SUB` out 1: ALU op; 0 = add, 1 = sub.
- `PC_load` out 1: PC update strobe.
- `select_flags` out 3: next-PC condition select.
  - 0 = sequential.
  - 1 = BEQ (zero).
  - 2 = BNE.
  - 3 = BLT (negative).
  - 4 = BGE.
- `illegal` out 1: illegal-instruction indicator.
- `state_dbg` out 3: current state encoding.

## Operation
- States (encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - Waits `FETCH_WAIT` cycles using an internal counter.
  - On the last FETCH cycle, `instr` is latched into an internal IR.
- DECODE:
  - Classifies IR by opcode and funct3.
  - R-type 0110011/000: funct7[5] selects sub.
  - addi 0010011/000.
  - ld 0000011/011.
  - sd 0100011/011.
  - branch 1100011 with funct3 000/001/100/101.
  - Anything else is illegal.
- Instruction sequences:
  - R-type and addi: FETCH → DECODE → EXEC → WB.
  - ld: FETCH → DECODE → EXEC → MEM → WB.
  - sd: FETCH → DECODE → EXEC → MEM.
  - branch: FETCH → DECODE → EXEC.
- All outputs are registered, as a Moore function of next state and IR.
- `OP_MEM_I` and `ADD_SUB`:
  - Valid from EXEC through the last state of the instruction.
  - 0 in FETCH and DECODE.
  - R-type: `OP_MEM_I`=0, `ADD_SUB`=funct7[5]. addi: `OP_MEM_I`=2. ld/sd: `OP_MEM_I`=1. Branch: `OP_MEM_I`=0, `ADD_SUB`=1 (compare by subtraction).
- `WE_mem`: asserted only in the MEM state of sd, for exactly one cycle.
- `WE_reg`: asserted only in WB, for exactly one cycle.
- `PC_load`:
  - Asserted for exactly one cycle in the final state of every instruction.
  - The final state is WB for R-type/addi/ld, MEM for sd, EXEC for branches.
  - `select_flags` is valid in the same cycle: the branch code for branches, 0 otherwise.
  - `select_flags` is 0 in all other cycles.
- The state after the final state is FETCH.
- Only one of `WE_mem` / `WE_reg` is ever high in a cycle; both are never high together.

## Timing
- Reset:
  - While `reset` is high at a clock edge, the state goes to FETCH and the wait counter clears.
  - All outputs are 0 after that edge, including `illegal`, and `state_dbg`=0.
- Reset mid-instruction aborts it with no further strobes; a pending `WE_*` or `PC_load` is not issued.
- Cycles per instruction (with FETCH_WAIT=0):
  - R-type and addi: 4.
  - ld: 5.
  - sd: 4.
  - branch: 3.
- Each instruction adds `FETCH_WAIT` cycles.
- `instr` is sampled only on the last FETCH edge. Changes to `instr` at any other time have no effect.
- The first FETCH begins on the first edge after `reset` deasserts.

## Configuration
- `CONTROL_FSM_ILLEGAL_TRAP_EN`:
  - Defined: an illegal instruction moves DECODE → HALT.
  - In HALT, `illegal`=1 and all strobes are 0, and the unit stays in HALT until `reset`.
  - Undefined: an illegal instruction is executed as a NOP. DECODE → EXEC, where `PC_load`=1 and `select_flags`=0, then FETCH.
  - When undefined, HALT is unreachable and `illegal` is tied to 0.

## Test plan
- Reset held 3 cycles, then released:
  - During reset, all outputs are 0 and `state_dbg`=0.
  - With `instr`=0x00103083 (ld x1,1(x0)), the sequence is 0,1,2,3,4.
  - `OP_MEM_I`=1 in EXEC..WB, `WE_reg`=1 only in WB, and `PC_load`=1 in WB.
- `instr`=0x002081B3 (add x3,x1,x2):
  - 4 cycles, `ADD_SUB`=0, `WE_reg` pulse in WB.
  - Then 0x40118233 (sub x4,x3,x1): same sequence with `ADD_SUB`=1.
- `instr`=0x003031A3 (sd x3,3(x0)):
  - `WE_mem`=1 and `PC_load`=1 together in MEM only.
  - `WE_reg` stays 0, and the state returns to FETCH.
- Branch opcode 1100011 with funct3=001 (bne):
  - 3 cycles.
  - In EXEC, `PC_load`=1, `select_flags`=2, `ADD_SUB`=1.
- `instr`=0x00A20493 (addi x9,x4,10) with FETCH_WAIT=2:
  - 6 cycles total, `OP_MEM_I`=2.
  - Changing `instr` during the first two FETCH cycles does not affect the decode.
- `instr`=0xFFFFFFFF:
  - With the macro: HALT and `illegal`=1, held until `reset`; asserting `reset` returns to FETCH with `illegal`=0.
  - Without the macro: a NOP with `PC_load`=1 and `select_flags`=0.
  - Separately, asserting `reset` during MEM of an sd suppresses `WE_mem`.
